// File: rtl/mode_dispatch_unit.sv
// ============================================================================
//  mode_dispatch_unit
//  In-order dispatch FIFO that steers decoded instructions to the scalar port
//  (one beat) or the vector port (LANES element beats). Optional mode checker
//  is built when MODE_CHECK_EN is defined.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module mode_dispatch_unit #(
  parameter int DEPTH   = 4,
  parameter int LANES   = 4,
  parameter int INSTR_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     inValid,
  output logic                     inReady,
  input  logic [INSTR_W-1:0]       inInstr,
  input  logic [1:0]               inOpType,
  input  logic [3:0]               inOpCode,
  input  logic                     inModeSel,
  output logic                     sValid,
  input  logic                     sReady,
  output logic [INSTR_W-1:0]       sInstr,
  output logic                     vValid,
  input  logic                     vReady,
  output logic [INSTR_W-1:0]       vInstr,
  output logic [$clog2(LANES)-1:0] vElem,
  output logic                     vLast,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     modeErr
);

  localparam int c_addrW = $clog2(DEPTH);
  localparam int c_elemW = $clog2(LANES);
  localparam int c_cntW  = c_addrW + 1;
  localparam logic [c_elemW-1:0] c_lastElem = c_elemW'(LANES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCALAR = 2'd1,
    VECTOR = 2'd2
  } state_t;

  state_t               r_state;
  logic [INSTR_W-1:0]   r_memInstr [DEPTH];
  logic                 r_memMode  [DEPTH];
  logic [c_addrW-1:0]   r_rdPtr;
  logic [c_addrW-1:0]   r_wrPtr;
  logic [c_cntW-1:0]    r_count;
  logic [c_elemW-1:0]   r_vElem;
  logic [INSTR_W-1:0]   r_sInstr;
  logic [INSTR_W-1:0]   r_vInstr;
  logic                 r_vLast;

  logic                 w_push;
  logic                 w_sFire;
  logic                 w_vFire;
  logic                 w_pop;
  logic [c_cntW-1:0]    w_remain;
  logic [c_cntW-1:0]    w_nextCount;
  logic [c_addrW-1:0]   w_nextRd;
  logic [INSTR_W-1:0]   w_headInstr;
  logic                 w_headMode;
  logic [c_elemW-1:0]   w_nextElem;

  assign inReady = (r_count < c_cntW'(DEPTH));
  assign count   = r_count;
  assign sValid  = (r_state == SCALAR);
  assign vValid  = (r_state == VECTOR);
  assign sInstr  = r_sInstr;
  assign vInstr  = r_vInstr;
  assign vElem   = r_vElem;
  assign vLast   = r_vLast;

  // Next head is resolved from the post-pop/post-push FIFO; when nothing
  // survives the pop, the only possible head is the entry being written now.
  always_comb begin
    w_push      = inValid && inReady;
    w_sFire     = sValid && sReady;
    w_vFire     = vValid && vReady;
    w_pop       = w_sFire || (w_vFire && (r_vElem == c_lastElem));
    w_remain    = r_count - c_cntW'(w_pop);
    w_nextCount = w_remain + c_cntW'(w_push);
    w_nextRd    = r_rdPtr + c_addrW'(w_pop);
    w_headInstr = r_memInstr[w_nextRd];
    w_headMode  = r_memMode[w_nextRd];
    if (w_remain == '0) begin
      w_headInstr = inInstr;
      w_headMode  = inModeSel;
    end
    w_nextElem  = w_vFire ? (r_vElem + c_elemW'(1)) : r_vElem;
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_memInstr[r_wrPtr] <= inInstr;
      r_memMode[r_wrPtr]  <= inModeSel;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_rdPtr  <= '0;
      r_wrPtr  <= '0;
      r_count  <= '0;
      r_vElem  <= '0;
      r_sInstr <= '0;
      r_vInstr <= '0;
      r_vLast  <= 1'b0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + c_addrW'(1);
      end
      r_rdPtr <= w_nextRd;
      r_count <= w_nextCount;
      r_vElem <= w_nextElem;
      if (w_nextCount == '0) begin
        r_state <= IDLE;
        r_vLast <= 1'b0;
      end else if (!w_headMode) begin
        r_state  <= SCALAR;
        r_sInstr <= w_headInstr;
        r_vLast  <= 1'b0;
      end else begin
        r_state  <= VECTOR;
        r_vInstr <= w_headInstr;
        r_vLast  <= (w_nextElem == c_lastElem);
      end
    end
  end

`ifdef MODE_CHECK_EN
  logic w_expMode;
  logic r_modeErr;

  always_comb begin
    w_expMode = 1'b0;
    if (!inOpType[1]) begin
      w_expMode = (inOpCode >= 4'd10);
    end else if (!inOpType[0]) begin
      w_expMode = (inOpCode >= 4'd2);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_modeErr <= 1'b0;
    end else if (w_push && (w_expMode != inModeSel)) begin
      r_modeErr <= 1'b1;
    end
  end

  assign modeErr = r_modeErr;
`else
  // Checker absent: the op fields only feed a constant-zero reduction.
  assign modeErr = &{1'b0, inOpType, inOpCode};
`endif

endmodule

`default_nettype wire
